// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the core's fetch/data ports, the unified memory and the arbiter.
// The master modport is the arbiter side; the slave modport is the core plus memory model side.
interface mem_port_arbiter_if;
    logic        halted;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_grant;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_grant;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;
    logic [1:0]  state_dbg;

    // Handshake: a requester holds *_req (and its address/data) until the
    // same-cycle *_grant; the result comes back as a one-cycle *_valid pulse.
    modport master (
        input  halted, if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_grant, if_valid, if_rdata, d_grant, d_valid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, busy, state_dbg
    );

    modport slave (
        output halted, if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_grant, if_valid, if_rdata, d_grant, d_valid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy, state_dbg
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch and data
// load/store; round-robin on ties, one access in flight at a time.
module mem_port_arbiter #(
    parameter int MEM_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_b,
    mem_port_arbiter_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_last_d;
    logic        r_win_d;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_if_rdata;
    logic [31:0] r_d_rdata;

    logic        w_idle;
    logic        w_if_elig;
    logic        w_d_elig;
    logic        w_grant_if;
    logic        w_grant_d;
    logic        w_mem_en;
    logic [31:0] w_sel_addr;

    assign w_idle    = (r_state == S_IDLE);
    assign w_if_elig = bus.if_req & ~bus.halted;
    assign w_d_elig  = bus.d_req;

    // On a tie the port that did not win last time goes first.
    assign w_grant_if = w_idle & w_if_elig & (~w_d_elig | r_last_d);
    assign w_grant_d  = w_idle & w_d_elig & (~w_if_elig | ~r_last_d);

    assign w_sel_addr = w_grant_d ? bus.d_addr : bus.if_addr;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_last_d   <= 1'b1;
            r_win_d    <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_if_rdata <= 32'd0;
            r_d_rdata  <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_if || w_grant_d) begin
                        r_win_d  <= w_grant_d;
                        r_last_d <= w_grant_d;
                        r_we     <= w_grant_d & bus.d_we;
                        r_addr   <= w_sel_addr & 32'hFFFF_FFFC;
                        r_wdata  <= w_grant_d ? bus.d_wdata : 32'd0;
                        r_state  <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    r_cnt   <= 4'(MEM_LATENCY - 1);
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        // Counter at zero marks the single cycle mem_rdata is valid.
                        if (!r_we) begin
                            if (r_win_d) r_d_rdata  <= bus.mem_rdata;
                            else         r_if_rdata <= bus.mem_rdata;
                        end
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign w_mem_en = (r_state == S_ACCESS);

    assign bus.if_grant  = w_grant_if;
    assign bus.d_grant   = w_grant_d;
    assign bus.mem_en    = w_mem_en;
    assign bus.mem_we    = w_mem_en & r_we;
    assign bus.mem_addr  = w_mem_en ? r_addr  : 32'd0;
    assign bus.mem_wdata = w_mem_en ? r_wdata : 32'd0;
    assign bus.if_valid  = (r_state == S_RESP) & ~r_win_d;
    assign bus.d_valid   = (r_state == S_RESP) &  r_win_d;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.busy      = ~w_idle;
    assign bus.state_dbg = r_state;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: main instance at latency 2, extra instances at 1 and 4.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if m ();
    mem_port_arbiter_if a1 ();
    mem_port_arbiter_if a4 ();

    mem_port_arbiter #(.MEM_LATENCY(2)) u_dut  (.clk(clk), .rst_b(rst_b), .bus(m));
    mem_port_arbiter #(.MEM_LATENCY(1)) u_lat1 (.clk(clk), .rst_b(rst_b), .bus(a1));
    mem_port_arbiter #(.MEM_LATENCY(4)) u_lat4 (.clk(clk), .rst_b(rst_b), .bus(a4));

    // Memory models: data = addr ^ 0x2008_0045, driven only in the exact latency cycle.
    logic [3:0]  m_cnt, a1_cnt, a4_cnt;
    logic [31:0] m_madr, a1_madr, a4_madr;

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            m_cnt <= 0; a1_cnt <= 0; a4_cnt <= 0;
            m_madr <= 0; a1_madr <= 0; a4_madr <= 0;
        end else begin
            if (m.mem_en) begin m_cnt <= 4'd2; m_madr <= m.mem_addr; end
            else if (m_cnt != 0) m_cnt <= m_cnt - 4'd1;
            if (a1.mem_en) begin a1_cnt <= 4'd1; a1_madr <= a1.mem_addr; end
            else if (a1_cnt != 0) a1_cnt <= a1_cnt - 4'd1;
            if (a4.mem_en) begin a4_cnt <= 4'd4; a4_madr <= a4.mem_addr; end
            else if (a4_cnt != 0) a4_cnt <= a4_cnt - 4'd1;
        end
    end

    assign m.mem_rdata  = (m_cnt  == 4'd1) ? (m_madr  ^ 32'h2008_0045) : 32'hBAD0_BAD0;
    assign a1.mem_rdata = (a1_cnt == 4'd1) ? (a1_madr ^ 32'h2008_0045) : 32'hBAD0_BAD0;
    assign a4.mem_rdata = (a4_cnt == 4'd1) ? (a4_madr ^ 32'h2008_0045) : 32'hBAD0_BAD0;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        m.halted = 0; m.if_req = 0; m.if_addr = 0;
        m.d_req = 0; m.d_we = 0; m.d_addr = 0; m.d_wdata = 0;
        a1.halted = 0; a1.if_req = 0; a1.if_addr = 0;
        a1.d_req = 0; a1.d_we = 0; a1.d_addr = 0; a1.d_wdata = 0;
        a4.halted = 0; a4.if_req = 0; a4.if_addr = 0;
        a4.d_req = 0; a4.d_we = 0; a4.d_addr = 0; a4.d_wdata = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_b = 0;
        repeat (2) @(posedge clk);
        #1 rst_b = 1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20; i++) begin
            mid();
            if (!m.busy) break;
            step();
        end
        check("idle_timeout", m.busy, 0);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n_grants;
        int last_g;
        int v1, v4, vc;
        logic [31:0] d1, d4, dc;

        idle_inputs();
        rst_b = 0;
        repeat (2) @(posedge clk);
        #1;
        mid();
        check("rst_busy", m.busy, 0);
        check("rst_mem_en", m.mem_en, 0);
        check("rst_if_rdata", m.if_rdata, 0);
        check("rst_d_rdata", m.d_rdata, 0);
        check("rst_state", m.state_dbg, 0);
        check("rst_valids", {m.if_valid, m.d_valid}, 0);
        @(posedge clk);
        #1 rst_b = 1;

        // Single fetch
        m.if_req = 1; m.if_addr = 32'h0000_0043;
        mid();
        check("t1_if_grant", m.if_grant, 1);
        check("t1_d_grant", m.d_grant, 0);
        step(); m.if_req = 0; m.if_addr = 0;
        mid();
        check("t1_mem_en", m.mem_en, 1);
        check("t1_mem_addr", m.mem_addr, 32'h0000_0040);
        check("t1_mem_we", m.mem_we, 0);
        check("t1_busy", m.busy, 1);
        step(); mid();
        check("t1_mem_en_c2", m.mem_en, 0);
        check("t1_mem_addr_c2", m.mem_addr, 0);
        step(); mid();
        check("t1_if_valid_c3", m.if_valid, 0);
        step(); mid();
        check("t1_if_valid_c4", m.if_valid, 1);
        check("t1_if_rdata", m.if_rdata, 32'h2008_0005);
        check("t1_d_valid_c4", m.d_valid, 0);
        step(); mid();
        check("t1_busy_c5", m.busy, 0);
        check("t1_if_valid_c5", m.if_valid, 0);
        step();

        // Data load
        m.d_req = 1; m.d_we = 0; m.d_addr = 32'h0000_0206;
        mid();
        check("ld_d_grant", m.d_grant, 1);
        check("ld_if_grant", m.if_grant, 0);
        step(); m.d_req = 0;
        mid();
        check("ld_mem_en", m.mem_en, 1);
        check("ld_mem_addr", m.mem_addr, 32'h0000_0204);
        check("ld_mem_we", m.mem_we, 0);
        step(); step(); step(); mid();
        check("ld_d_valid", m.d_valid, 1);
        check("ld_d_rdata", m.d_rdata, 32'h2008_0241);
        step(); step();

        // Store
        m.d_req = 1; m.d_we = 1; m.d_addr = 32'h0000_0100; m.d_wdata = 32'hDEAD_BEEF;
        mid();
        check("st_d_grant", m.d_grant, 1);
        step(); m.d_req = 0; m.d_we = 0; m.d_wdata = 0;
        mid();
        check("st_mem_en", m.mem_en, 1);
        check("st_mem_we", m.mem_we, 1);
        check("st_mem_addr", m.mem_addr, 32'h0000_0100);
        check("st_mem_wdata", m.mem_wdata, 32'hDEAD_BEEF);
        step(); mid();
        check("st_mem_we_idle", m.mem_we, 0);
        check("st_mem_wdata_idle", m.mem_wdata, 0);
        step(); step(); mid();
        check("st_d_valid", m.d_valid, 1);
        check("st_d_rdata_kept", m.d_rdata, 32'h2008_0241);
        check("st_if_rdata_kept", m.if_rdata, 32'h2008_0005);
        step(); step();

        // Contention from reset: IF, D, IF, D five cycles apart
        do_reset();
        exp_q = '{32'd0, 32'd1, 32'd0, 32'd1};
        m.if_req = 1; m.if_addr = 32'h0000_0010;
        m.d_req = 1; m.d_we = 0; m.d_addr = 32'h0000_0020;
        n_grants = 0; last_g = -1;
        for (int i = 0; i < 20; i++) begin
            mid();
            check("ct_exclusive", m.if_grant & m.d_grant, 0);
            if (m.if_grant || m.d_grant) begin
                check("ct_grant_order", {31'd0, m.d_grant},
                      (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF);
                if (last_g >= 0) check("ct_grant_spacing", i - last_g, 5);
                last_g = i;
                n_grants++;
            end
            step();
        end
        check("ct_grant_count", n_grants, 4);
        m.if_req = 0; m.d_req = 0;
        wait_idle();

        // Halt: only data is served
        m.halted = 1; m.if_req = 1; m.d_req = 1;
        n_grants = 0;
        for (int i = 0; i < 15; i++) begin
            mid();
            check("halt_no_if_grant", m.if_grant, 0);
            if (m.d_grant) n_grants++;
            step();
        end
        check("halt_d_grants", n_grants, 3);
        m.halted = 0; m.if_req = 0; m.d_req = 0;
        wait_idle();

        // Halt rising with a fetch in flight
        m.if_req = 1; m.if_addr = 32'h0000_0080;
        mid();
        check("hf_if_grant", m.if_grant, 1);
        step(); m.halted = 1;
        vc = 99; dc = 0;
        for (int c = 1; c <= 7; c++) begin
            mid();
            check("hf_no_if_grant", m.if_grant, 0);
            if (m.if_valid && vc == 99) begin vc = c; dc = m.if_rdata; end
            step();
        end
        check("hf_valid_cycle", vc, 4);
        check("hf_if_rdata", dc, 32'h2008_00C5);
        m.if_req = 0; m.halted = 0;
        wait_idle();

        // Reset during WAIT
        m.d_req = 1; m.d_we = 0; m.d_addr = 32'h0000_0300;
        mid();
        check("rw_d_grant", m.d_grant, 1);
        step(); m.d_req = 0;
        step(); mid();
        check("rw_busy_wait", m.busy, 1);
        check("rw_state_wait", m.state_dbg, 2);
        rst_b = 0;
        #1;
        check("rw_busy", m.busy, 0);
        check("rw_mem_en", m.mem_en, 0);
        check("rw_valids", {m.if_valid, m.d_valid}, 0);
        check("rw_d_rdata", m.d_rdata, 0);
        @(posedge clk);
        #1 rst_b = 1;
        for (int i = 0; i < 6; i++) begin
            mid();
            check("rw_no_valid", {m.if_valid, m.d_valid}, 0);
            step();
        end
        m.if_req = 1; m.d_req = 1;
        mid();
        check("rw_tie_if_grant", m.if_grant, 1);
        check("rw_tie_d_grant", m.d_grant, 0);
        step(); m.if_req = 0; m.d_req = 0;
        wait_idle();

        // Latency 1 and 4 instances
        a1.d_req = 1; a1.d_addr = 32'h0000_0010;
        a4.d_req = 1; a4.d_addr = 32'h0000_0020;
        mid();
        check("lat1_d_grant", a1.d_grant, 1);
        check("lat4_d_grant", a4.d_grant, 1);
        step(); a1.d_req = 0; a4.d_req = 0;
        v1 = 99; v4 = 99; d1 = 0; d4 = 0;
        for (int c = 1; c <= 9; c++) begin
            mid();
            if (a1.d_valid && v1 == 99) begin v1 = c; d1 = a1.d_rdata; end
            if (a4.d_valid && v4 == 99) begin v4 = c; d4 = a4.d_rdata; end
            step();
        end
        check("lat1_valid_cycle", v1, 3);
        check("lat4_valid_cycle", v4, 6);
        check("lat1_d_rdata", d1, 32'h2008_0055);
        check("lat4_d_rdata", d4, 32'h2008_0065);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between instruction fetch and data load/store requesters of the MIPS core.
- Arbitrates between the two requesters, sequences each access through a fixed-latency memory, and returns read data or a write acknowledgement to the winner.
- Sits between the core's fetch/data ports and the memory model; one access in flight at a time.

Parameters:
MEM_LATENCY, 2, cycles from the memory enable cycle until mem_rdata is valid; legal range 1..15.

Ports:
clk  input  1  clock, rising edge
rst_b  input  1  reset, asynchronous, active-low
halted  input  1  core halted; blocks new fetch grants
if_req  input  1  fetch request, level, held until if_grant
if_addr  input  32  fetch byte address
if_grant  output  1  fetch request accepted this cycle
if_valid  output  1  one-cycle pulse: if_rdata valid
if_rdata  output  32  fetched instruction
d_req  input  1  data request, level, held until d_grant
d_we  input  1  1 = store, 0 = load
d_addr  input  32  data byte address
d_wdata  input  32  store data, byte 0 in [31:24]
d_grant  output  1  data request accepted this cycle
d_valid  output  1  one-cycle pulse: load data valid or store done
d_rdata  output  32  load data, byte 0 in [31:24]
mem_en  output  1  memory access strobe, one cycle per access
mem_we  output  1  write enable, qualified by mem_en
mem_addr  output  32  word-aligned address
mem_wdata  output  32  write data
mem_rdata  input  32  read data, valid MEM_LATENCY cycles after the mem_en cycle
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst_b low, asynchronous): state = IDLE; latency counter = 0; last_winner = DATA; captured request registers cleared.
- Reset values: all outputs 0, including if_rdata and d_rdata. mem_en drops immediately and any in-flight access is discarded with no valid pulse.
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE: grants are combinational from the current request inputs.
  - Fetch is eligible when if_req=1 and halted=0. Data is eligible when d_req=1.
  - One eligible requester: it is granted.
  - Both eligible: grant the port that is not last_winner. After reset, fetch wins the first tie.
  - On a grant: capture the address as {addr[31:2],2'b00}, plus we (fetch captures 0) and wdata. Update last_winner and go to ACCESS.
  - No grant: remain in IDLE.
- Grants are asserted only in IDLE and are mutually exclusive. A requester may deassert or change its request in the cycle after its grant.
- ACCESS (1 cycle):
  - mem_en=1; mem_addr, mem_we and mem_wdata driven from the captured registers.
  - Load counter with MEM_LATENCY-1 and go to WAIT.
  - mem_addr, mem_we and mem_wdata are 0 whenever mem_en=0.
- WAIT:
  - Counter != 0: decrement.
  - Counter == 0: this is the cycle in which mem_rdata is valid. On a read, register mem_rdata into the winner's rdata; then go to RESP.
- RESP (1 cycle): the winner's valid pulses for one cycle, then go to IDLE.
  - Store: d_valid pulses and d_rdata keeps its previous value.
  - rdata holds its value until the next read completes on that port.
- Timing from grant cycle 0: mem_en in cycle 1, mem_rdata sampled in cycle 1+MEM_LATENCY, valid in cycle 2+MEM_LATENCY, next grant possible in cycle 3+MEM_LATENCY. Issue interval is 3+MEM_LATENCY cycles.
- halted rising while a fetch is in flight: that fetch completes normally, including if_valid. Subsequent fetches are not granted while halted=1; data requests are still served.
- if_req and d_req both held continuously: grants strictly alternate.
- Requests arriving in ACCESS, WAIT or RESP are ignored until IDLE; they are not queued.

Test Plan:
- Single fetch, MEM_LATENCY=2: if_req, if_addr=0x0000_0043 in cycle 0 -> if_grant in cycle 0; mem_en=1, mem_addr=0x0000_0040, mem_we=0 in cycle 1; model returns 0x2008_0005 in cycle 3 -> if_valid=1, if_rdata=0x2008_0005 in cycle 4; busy=0 in cycle 5.
- Store: d_req, d_we=1, d_addr=0x100, d_wdata=0xDEAD_BEEF -> mem_en=mem_we=1, mem_addr=0x100, mem_wdata=0xDEAD_BEEF in cycle 1; d_valid in cycle 4; d_rdata unchanged.
- Contention: if_req and d_req held from reset -> grant order IF, D, IF, D; grants spaced 5 cycles apart; never both grants high together.
- Halt: halted=1 with if_req and d_req held -> only d_grant ever asserts; a fetch already in flight when halt rises still produces if_valid.
- Reset mid-access: rst_b low during WAIT -> mem_en, busy and both valids go to 0 immediately; no valid pulse follows; after release, the first tie grants fetch.
- MEM_LATENCY=1 and MEM_LATENCY=4: valid arrives exactly 3 and 6 cycles after grant respectively.
